// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - FIFO-fed UART transmitter, 8 data bits, optional parity, 1/2 stop bits
module uart_tx #(
    parameter logic [7:0] OVERSAMPLE = 8'd16,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [15:0]                   baud_div,
    input  logic [1:0]                    parity,
    input  logic                          stop2,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t         state_q, state_d;
    logic [15:0]    div_q;
    logic [7:0]     os_q, os_d;
    logic [2:0]     bitn_q, bitn_d;
    logic [7:0]     sh_q, sh_d;
    logic           tx_q, tx_d;
    logic           par_en_q, par_en_d;
    logic           par_bit_q, par_bit_d;
    logic           stop2_q, stop2_d;
    logic           second_q, second_d;

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_q, rd_q;
    logic [LW-1:0]  cnt_q;

    logic           tick, push, pop, load_frame;
    logic [7:0]     head;

    assign tick    = (div_q == 16'd0);
    assign ready_o = (cnt_q != LW'(FIFO_DEPTH));
    assign push    = valid_i && ready_o;
    assign head    = mem_q[rd_q];
    assign tx_o    = tx_q;
    assign busy_o  = (state_q != S_IDLE) || (cnt_q != '0);
    assign level_o = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 16'd0;
        end else if (tick) begin
            div_q <= baud_div;
        end else begin
            div_q <= div_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            os_q      <= 8'd0;
            bitn_q    <= 3'd0;
            sh_q      <= 8'd0;
            tx_q      <= 1'b1;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            second_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_q      <= os_d;
            bitn_q    <= bitn_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            second_q  <= second_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        os_d       = os_q;
        bitn_d     = bitn_q;
        sh_d       = sh_q;
        tx_d       = tx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        second_d   = second_q;
        load_frame = 1'b0;
        pop        = 1'b0;

        if (tick) begin
            if (state_q == S_IDLE) begin
                tx_d = 1'b1;
                if (cnt_q != '0) load_frame = 1'b1;
            end else if (os_q != 8'd0) begin
                os_d = os_q - 8'd1;
            end else begin
                os_d = OVERSAMPLE - 8'd1;
                case (state_q)
                    S_START: begin
                        tx_d    = sh_q[0];
                        sh_d    = {1'b0, sh_q[7:1]};
                        bitn_d  = 3'd0;
                        state_d = S_DATA;
                    end
                    S_DATA: begin
                        if (bitn_q == 3'd7) begin
                            tx_d    = par_en_q ? par_bit_q : 1'b1;
                            state_d = par_en_q ? S_PAR : S_STOP;
                        end else begin
                            tx_d   = sh_q[0];
                            sh_d   = {1'b0, sh_q[7:1]};
                            bitn_d = bitn_q + 3'd1;
                        end
                    end
                    S_PAR: begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        if (stop2_q && !second_q) begin
                            second_d = 1'b1;
                        end else if (cnt_q != '0) begin
                            load_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Shared by IDLE and end-of-stop so queued bytes follow with no idle gap.
        if (load_frame) begin
            pop       = 1'b1;
            sh_d      = head;
            par_en_d  = (parity == 2'd1) || (parity == 2'd2);
            par_bit_d = (parity == 2'd2) ? ~^head : ^head;
            stop2_d   = stop2;
            second_d  = 1'b0;
            tx_d      = 1'b0;
            os_d      = OVERSAMPLE - 8'd1;
            state_d   = S_START;
        end
    end
endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that pairs with the 16x-oversampling receiver on the PLC serial port. It accepts bytes through a valid/ready handshake into a small FIFO and serializes them LSB-first on `tx_o`. Each frame is 1 start bit, 8 data bits, an optional even/odd parity bit, and 1 or 2 stop bits. Its baud-tick generator uses the same `baud_div` value and 16x tick convention as the receiver, so one CSR value configures both ends.

## Interface
- `OVERSAMPLE`, default 8'd16: ticks per bit; must match the receiver.
- `FIFO_DEPTH`, default 4: TX FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; everything is synchronous to its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_i`  in  8  byte to transmit.
- `valid_i`  in  1  `data_i` is valid.
- `ready_o`  out  1  FIFO can accept a byte. Equals (level != FIFO_DEPTH).
- `baud_div`  in  16  tick period minus 1, in clk cycles.
- `parity`  in  2  0 = none, 1 = even, 2 = odd, 3 = treated as none.
- `stop2`  in  1  0 = 1 stop bit, 1 = 2 stop bits.
- `tx_o`  out  1  serial line; idle is 1.
- `busy_o`  out  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- **Tick generator**
  - 16-bit down-counter `div`.
  - When `div`==0: reload `baud_div` and pulse `tick` for 1 clk. Otherwise decrement.
  - Tick period = `baud_div`+1 clks; `baud_div`=0 gives a tick every clk.
  - Bit period = OVERSAMPLE × (`baud_div`+1) clks.
- **FIFO**
  - Push when `valid_i && ready_o`.
  - Pop when the FSM starts a frame.
  - Push and pop in the same cycle: level unchanged, both take effect.
  - No push while full, because `ready_o`=0.
  - Pointers wrap modulo FIFO_DEPTH.
- **Frame config latch**: `parity` and `stop2` are latched at the pop. Changes mid-frame do not affect the frame in flight.
- **FSM**: states IDLE, START, DATA, PAR, STOP. All state actions occur only on `tick`. A bit counter `os` counts OVERSAMPLE ticks per bit.
  - **IDLE**: `tx_o`=1. On tick with level≠0: pop into shift reg `sh`, compute parity bit, set `tx_o`=0, `os`=OVERSAMPLE-1, go to START.
  - **START**: when `os`==0, drive `tx_o`=`sh[0]`, shift `sh` right, `bitn`=0, reload `os`, go to DATA.
  - **DATA**: when `os`==0:
    - If `bitn`==7, go to PAR when parity is 1 or 2, otherwise to STOP; drive the parity bit or 1 accordingly.
    - Otherwise drive the next bit and increment `bitn`.
    - Reload `os` in both cases.
  - **PAR**: parity bit = ^data for even, ~^data for odd. When `os`==0, drive 1, go to STOP, reload `os`.
  - **STOP**: one OVERSAMPLE period, or two when `stop2`=1 (a second-stop flag).
    - At the end, if level≠0: pop and start the next frame with no idle gap (`tx_o`=0 immediately, state START).
    - Otherwise go to IDLE.
- `data_i` values are transmitted in push order.

## Timing
- **Reset values**: `tx_o`=1, `ready_o`=1, `busy_o`=0, `level_o`=0. FSM is in IDLE, FIFO is empty, `div`=0, `os`=0, `bitn`=0.
- **Reset mid-frame**: on the cycle after `rst` is sampled, `tx_o`=1 and the FIFO is flushed. The partial frame is abandoned.
- All outputs are registered except `ready_o`, `busy_o` and `level_o`, which are decoded from registers.
- **Latency**:
  - A pushed byte is visible in `level_o` on the next clk.
  - `tx_o` falls 1 clk after the first tick that finds level≠0 in IDLE, so the worst case is `baud_div`+2 clks after the push.
- **Bit durations**: every bit, including each stop bit, lasts exactly OVERSAMPLE ticks. Frame length is (10 + P + S) × OVERSAMPLE ticks, where P = parity enabled (0/1) and S = `stop2` (0/1).
- **Idle gap between frames**: zero when the next byte is in the FIFO by the final stop tick.
- **Changing `baud_div` mid-frame**: takes effect at the next `div` reload; no other guarantee.

## Test plan
- **Single byte, no parity, 1 stop.** Reset, then `baud_div`=0, parity=0, stop2=0, push 0x55. Required: `tx_o` = 0, 1,0,1,0,1,0,1,0, 1, each bit 16 clks, 160 clks total. `busy_o` drops the cycle IDLE is re-entered.
- **Even and odd parity.** `baud_div`=3, push 0xA7 with parity=1, then parity=2. Required: parity bit is 1 for even and 0 for odd. Each bit lasts 64 clks; each frame is 11 bits.
- **Back-to-back frames with two stop bits.** stop2=1, push 0x00, 0xFF, 0x3C while not full. Required: three frames with no idle gap. The stop high lasts exactly 32 ticks between frames. Bytes arrive in order.
- **FIFO full, boundary push/pop.** Hold `valid_i`=1 with FIFO_DEPTH=4. Required: `ready_o`=0 once `level_o`=4. `ready_o` returns to 1 the clk after the pop. A simultaneous push and pop leaves the level unchanged. No byte is lost or duplicated.
- **Reset mid-frame.** Assert `rst` during DATA bit 3 with 2 bytes queued. Required: `tx_o`=1, `level_o`=0 and `busy_o`=0 on the next clk. A subsequent push of 0x81 transmits correctly.
- **Loopback against the receiver.** Drive random bytes with random parity/stop2 into the receiver, with matching `baud_div`. Required: each byte is received with `valid_o`, and `framing_err`=`parity_err`=0.
